// File: rtl/slave_checksum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slave_checksum_pkg
// Purpose  : Shared state encoding and default widths for checksum slaves.
// Revision : 1.0
// ============================================================================
package slave_checksum_pkg;

  localparam int c_DEF_ADDR_W = 8;
  localparam int c_DEF_DATA_W = 8;
  localparam int c_DEF_SUM_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/slave_checksum_if.sv
`default_nettype none
// ============================================================================
// Module   : slave_checksum_if
// Purpose  : Trigger/done handshake plus memory read port of a checksum slave.
// Revision : 1.0
// ============================================================================
interface slave_checksum_if
  import slave_checksum_pkg::*;
#(
  parameter int ADDR_W = c_DEF_ADDR_W,
  parameter int DATA_W = c_DEF_DATA_W,
  parameter int SUM_W  = c_DEF_SUM_W
) ();

  logic              trigger;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              done;
  logic [SUM_W-1:0]  result;
  logic              overflow;
  logic              busy;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  trigger, base_addr, length, mem_rdata,
    output done, result, overflow, busy, mem_rd, mem_addr
  );

  modport master (
    output trigger, base_addr, length, mem_rdata,
    input  done, result, overflow, busy, mem_rd, mem_addr
  );

endinterface
`default_nettype wire

// File: rtl/slave_checksum_accum.sv
`default_nettype none
// ============================================================================
// Module   : checksum_accum
// Purpose  : Modular accumulator with sticky carry; outputs include this cycle's word.
// Revision : 1.0
// ============================================================================
module checksum_accum #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_clear,
  input  wire logic              i_enable,
  input  wire logic [DATA_W-1:0] i_data,
  output logic      [SUM_W-1:0]  o_sum,
  output logic                   o_carry
);

  logic [SUM_W-1:0] r_sum;
  logic             r_carry;
  logic [SUM_W:0]   w_add;
  logic [SUM_W-1:0] w_sum_nxt;
  logic             w_carry_nxt;

  assign w_add = {1'b0, r_sum} + {{(SUM_W + 1 - DATA_W){1'b0}}, i_data};

  // Clear wins over enable so a job accept always starts from zero.
  always_comb begin
    w_sum_nxt   = r_sum;
    w_carry_nxt = r_carry;
    if (i_clear) begin
      w_sum_nxt   = '0;
      w_carry_nxt = 1'b0;
    end else if (i_enable) begin
      w_sum_nxt   = w_add[SUM_W-1:0];
      w_carry_nxt = r_carry | w_add[SUM_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_sum   <= w_sum_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign o_sum   = w_sum_nxt;
  assign o_carry = w_carry_nxt;

endmodule
`default_nettype wire

// File: rtl/slave_checksum.sv
`default_nettype none
// ============================================================================
// Module   : slave_checksum
// Purpose  : Trigger/done responder that checksums a memory block of LEN words.
// Revision : 1.0
// ============================================================================
module slave_checksum
  import slave_checksum_pkg::*;
#(
  parameter int ADDR_W = c_DEF_ADDR_W,
  parameter int DATA_W = c_DEF_DATA_W,
  parameter int SUM_W  = c_DEF_SUM_W
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  slave_checksum_if.slave bus
);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W:0]   r_remain, w_remain_nxt;
  logic              r_rd_valid;
  logic [SUM_W-1:0]  r_result;
  logic              r_overflow;
  logic              w_mem_rd;
  logic              w_publish;
  logic              w_accept;
  logic              w_busy;
  logic [SUM_W-1:0]  w_sum;
  logic              w_carry;

  assign w_accept = (r_state == ST_IDLE) && bus.trigger;
  assign w_busy   = (r_state == ST_READ) || (r_state == ST_DRAIN);

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_remain_nxt = r_remain;
    w_mem_rd     = 1'b0;
    w_publish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.trigger) begin
          w_addr_nxt   = bus.base_addr;
          w_remain_nxt = bus.length;
          w_state_nxt  = (bus.length != '0) ? ST_READ : ST_DRAIN;
        end
      end
      ST_READ: begin
        w_mem_rd = 1'b1;
        if (!bus.trigger) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_addr_nxt   = r_addr + 1'b1;
          w_remain_nxt = r_remain - 1'b1;
          if (r_remain == {{ADDR_W{1'b0}}, 1'b1}) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!bus.trigger) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
          w_publish   = 1'b1;
        end
      end
      ST_DONE: begin
        if (!bus.trigger) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_rd_valid <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_remain   <= w_remain_nxt;
      r_rd_valid <= w_mem_rd;
      if (w_publish) begin
        r_result   <= w_sum;
        r_overflow <= w_carry;
      end
    end
  end

  // Read data landing after an abort (state back in IDLE) is ignored.
  checksum_accum #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_accept),
    .i_enable (r_rd_valid && w_busy),
    .i_data   (bus.mem_rdata),
    .o_sum    (w_sum),
    .o_carry  (w_carry)
  );

  assign bus.mem_rd   = w_mem_rd;
  assign bus.mem_addr = r_addr;
  assign bus.done     = (r_state == ST_DONE);
  assign bus.result   = r_result;
  assign bus.overflow = r_overflow;
  assign bus.busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_slave_checksum.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_checksum
// Purpose  : Directed self-checking bench for slave_checksum (16- and 8-bit sums).
// Revision : 1.0
// ============================================================================
module tb_slave_checksum;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   rd_cnt = 0;
  int   cnt0;
  logic [7:0] mem16 [256];
  logic [7:0] mem8  [256];
  logic [7:0] wrap_addr [3];

  slave_checksum_if #(.ADDR_W(8), .DATA_W(8), .SUM_W(16)) a16 ();
  slave_checksum_if #(.ADDR_W(8), .DATA_W(8), .SUM_W(8))  a8  ();

  slave_checksum #(.ADDR_W(8), .DATA_W(8), .SUM_W(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a16)
  );

  slave_checksum #(.ADDR_W(8), .DATA_W(8), .SUM_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (a16.mem_rd === 1'b1) a16.mem_rdata <= mem16[a16.mem_addr];
    if (a8.mem_rd === 1'b1)  a8.mem_rdata  <= mem8[a8.mem_addr];
    if (a16.mem_rd === 1'b1) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem16[a] = 8'(a + 1);
      mem8[a]  = 8'hFF;
    end
    wrap_addr[0] = 8'hFE;
    wrap_addr[1] = 8'hFF;
    wrap_addr[2] = 8'h00;
    a16.mem_rdata = '0;
    a8.mem_rdata  = '0;
    rst_n = 1'b0;
    a16.trigger = 1'b0; a16.base_addr = '0; a16.length = '0;
    a8.trigger  = 1'b0; a8.base_addr  = '0; a8.length  = '0;

    // Reset state
    step(2);
    check("rst_done",     a16.done,     0);
    check("rst_mem_rd",   a16.mem_rd,   0);
    check("rst_mem_addr", a16.mem_addr, 0);
    check("rst_result",   a16.result,   0);
    check("rst_overflow", a16.overflow, 0);
    check("rst_busy",     a16.busy,     0);
    check("rst_result8",  a8.result,    0);

    // Idle with trigger low: no reads
    rst_n = 1'b1;
    step(10);
    check("idle_rd_cnt", rd_cnt, 0);
    check("idle_busy",   a16.busy, 0);

    // Basic job: base 0x10, length 4 -> 0x11+0x12+0x13+0x14 = 0x4A
    a16.base_addr = 8'h10; a16.length = 9'd4; a16.trigger = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("basic_rd",   a16.mem_rd,   1);
      check("basic_addr", a16.mem_addr, 32'h10 + i);
      check("basic_done_early", a16.done, 0);
    end
    step(1);
    check("basic_drain_rd",   a16.mem_rd, 0);
    check("basic_drain_busy", a16.busy,   1);
    check("basic_drain_done", a16.done,   0);
    step(1);
    check("basic_done",     a16.done,     1);
    check("basic_result",   a16.result,   16'h004A);
    check("basic_overflow", a16.overflow, 0);
    check("basic_busy",     a16.busy,     0);

    // Trigger held through DONE: no second job
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("hold_done", a16.done,   1);
      check("hold_rd",   a16.mem_rd, 0);
    end
    check("hold_rd_cnt", rd_cnt, 4);
    a16.trigger = 1'b0;
    step(1);
    check("drop_done", a16.done, 0);

    // Back-to-back after one low cycle: base 0, length 2 -> 1+2 = 3
    a16.base_addr = 8'h00; a16.length = 9'd2; a16.trigger = 1'b1;
    step(1);
    check("b2b_addr0", a16.mem_addr, 0);
    step(1);
    check("b2b_addr1",       a16.mem_addr, 1);
    check("b2b_result_hold", a16.result,   16'h004A);
    step(2);
    check("b2b_done",   a16.done,   1);
    check("b2b_result", a16.result, 16'h0003);
    a16.trigger = 1'b0;
    step(1);

    // Abort after three reads
    a16.base_addr = 8'h20; a16.length = 9'd8; a16.trigger = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("abort_rd",   a16.mem_rd,   1);
      check("abort_addr", a16.mem_addr, 32'h20 + i);
    end
    a16.trigger = 1'b0;
    step(1);
    check("abort_rd_off", a16.mem_rd, 0);
    check("abort_busy",   a16.busy,   0);
    step(3);
    check("abort_done",     a16.done,     0);
    check("abort_result",   a16.result,   16'h0003);
    check("abort_overflow", a16.overflow, 0);

    // Zero length
    cnt0 = rd_cnt;
    a16.length = 9'd0; a16.trigger = 1'b1;
    step(1);
    check("zero_busy", a16.busy,   1);
    check("zero_rd",   a16.mem_rd, 0);
    check("zero_done_early", a16.done, 0);
    step(1);
    check("zero_done",     a16.done,     1);
    check("zero_result",   a16.result,   0);
    check("zero_overflow", a16.overflow, 0);
    check("zero_rd_cnt",   rd_cnt,       cnt0);
    a16.trigger = 1'b0;
    step(1);

    // Address wrap and overflow on the 8-bit sum: 3 * 0xFF = 0x2FD
    a8.base_addr = 8'hFE; a8.length = 9'd3; a8.trigger = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("wrap_addr", a8.mem_addr, wrap_addr[i]);
    end
    step(2);
    check("wrap_done",     a8.done,     1);
    check("wrap_result",   a8.result,   8'hFD);
    check("wrap_overflow", a8.overflow, 1);
    a8.trigger = 1'b0;
    step(1);

    // Full range: 256 words from 0x80, sum of 0..255 = 0x7F80
    cnt0 = rd_cnt;
    a16.base_addr = 8'h80; a16.length = 9'd256; a16.trigger = 1'b1;
    step(256);
    check("full_last_rd",   a16.mem_rd,   1);
    check("full_last_addr", a16.mem_addr, 8'h7F);
    step(1);
    check("full_drain_rd", a16.mem_rd, 0);
    step(1);
    check("full_done",     a16.done,     1);
    check("full_result",   a16.result,   16'h7F80);
    check("full_overflow", a16.overflow, 0);
    check("full_rd_cnt",   rd_cnt - cnt0, 256);
    a16.trigger = 1'b0;
    step(1);

    // Asynchronous reset mid-job
    a16.base_addr = 8'h00; a16.length = 9'd8; a16.trigger = 1'b1;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_done",     a16.done,     0);
    check("arst_mem_rd",   a16.mem_rd,   0);
    check("arst_mem_addr", a16.mem_addr, 0);
    check("arst_result",   a16.result,   0);
    check("arst_overflow", a16.overflow, 0);
    check("arst_busy",     a16.busy,     0);
    check("arst_result8",  a8.result,    0);
    a16.trigger = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    check("post_rst_done", a16.done, 0);
    check("post_rst_busy", a16.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
